// File: rtl/sfu_row_reduce_if.sv
// Stream bundle for sfu_row_reduce: input beat stream and output beat stream, both ready/valid.
interface sfu_row_reduce_if #(
    parameter int DATA_W = 256
);
    logic              ext_data_i_valid;
    logic              ext_data_i_ready;
    logic [DATA_W-1:0] ext_data_i_bits;
    logic              ext_data_o_valid;
    logic              ext_data_o_ready;
    logic [DATA_W-1:0] ext_data_o_bits;

    modport master (
        output ext_data_i_valid, ext_data_i_bits, ext_data_o_ready,
        input  ext_data_i_ready, ext_data_o_valid, ext_data_o_bits
    );

    modport slave (
        input  ext_data_i_valid, ext_data_i_bits, ext_data_o_ready,
        output ext_data_i_ready, ext_data_o_valid, ext_data_o_bits
    );
endinterface

// File: rtl/sfu_row_reduce.sv
// Row reduction engine: per job reduces one row to max / sum, or replays it as x - rowmax.
// Optional macro SFU_ROW_REDUCE_ARGMAX_EN adds first-occurrence argmax to the MAX result.
module sfu_row_reduce #(
    parameter int LANES     = 16,
    parameter int ELEM_W    = 16,
    parameter int MAX_BEATS = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    sfu_row_reduce_if.slave        bus,
    input  logic [31:0]            ext_csr_i_0,
    input  logic                   ext_start_i,
    output logic                   ext_busy_o
);
    localparam int DATA_W = LANES * ELEM_W;
    localparam int BEAT_W = $clog2(MAX_BEATS) + 1;
    localparam int IDX_W  = $clog2(LANES * MAX_BEATS);
    localparam int ACC_W  = ELEM_W + IDX_W;
    localparam int PTR_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    localparam logic [1:0] M_MAX    = 2'd0;
    localparam logic [1:0] M_SUM    = 2'd1;
    localparam logic [1:0] M_MAXSUB = 2'd2;
    localparam logic [1:0] M_RSVD   = 2'd3;

    localparam logic signed [ELEM_W-1:0] ELEM_MIN = {1'b1, {(ELEM_W-1){1'b0}}};

`ifdef SFU_ROW_REDUCE_ARGMAX_EN
    if (ELEM_W + IDX_W > DATA_W) begin : g_idx_fit
        $error("sfu_row_reduce: argmax index does not fit in the output beat");
    end
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RESULT, S_REPLAY} state_e;

    state_e                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic [BEAT_W-1:0]          count_q, count_d;
    logic [BEAT_W-1:0]          ctr_q, ctr_d;
    logic [BEAT_W-1:0]          rptr_q, rptr_d;
    logic signed [ELEM_W-1:0]   max_q, max_d;
    logic signed [ACC_W-1:0]    sum_q, sum_d;
    logic                       o_valid_q, o_valid_d;
    logic [DATA_W-1:0]          o_bits_q, o_bits_d;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [IDX_W-1:0]           beat_lane;
`endif

    logic [DATA_W-1:0]          row_buf [MAX_BEATS];
    logic [DATA_W-1:0]          rd_beat;
    logic [DATA_W-1:0]          replay_beat;
    logic signed [ELEM_W-1:0]   beat_max;
    logic signed [ACC_W-1:0]    beat_sum;
    logic                       in_hs, out_hs;
    logic [1:0]                 cfg_mode;
    logic [BEAT_W-1:0]          cfg_cnt;
    logic                       unused_csr;

    assign cfg_mode   = ext_csr_i_0[31:30];
    assign cfg_cnt    = ext_csr_i_0[BEAT_W-1:0];
    assign unused_csr = ^ext_csr_i_0[29:BEAT_W];

    assign bus.ext_data_i_ready = (state_q == S_LOAD);
    assign bus.ext_data_o_valid = o_valid_q;
    assign bus.ext_data_o_bits  = o_bits_q;
    assign ext_busy_o           = (state_q != S_IDLE);

    assign in_hs  = bus.ext_data_i_valid & bus.ext_data_i_ready;
    assign out_hs = o_valid_q & bus.ext_data_o_ready;

    // Strict '>' keeps the lowest lane on ties, so argmax is the first occurrence.
    always_comb begin : lane_reduce
        logic signed [ELEM_W-1:0] e;
        e        = '0;
        beat_max = bus.ext_data_i_bits[ELEM_W-1:0];
        beat_sum = '0;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
        beat_lane = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            e        = bus.ext_data_i_bits[k*ELEM_W +: ELEM_W];
            beat_sum = beat_sum + {{(ACC_W-ELEM_W){e[ELEM_W-1]}}, e};
            if (e > beat_max) begin
                beat_max = e;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
                beat_lane = IDX_W'(k);
`endif
            end
        end
    end

    // x - max is never positive; only the negative side can overflow ELEM_W.
    always_comb begin : replay_sub
        logic signed [ELEM_W-1:0] x;
        logic        [ELEM_W:0]   diff;
        x           = '0;
        diff        = '0;
        replay_beat = '0;
        rd_beat     = row_buf[rptr_q[PTR_W-1:0]];
        for (int k = 0; k < LANES; k++) begin
            x    = rd_beat[k*ELEM_W +: ELEM_W];
            diff = {x[ELEM_W-1], x} - {max_q[ELEM_W-1], max_q};
            if (diff[ELEM_W] != diff[ELEM_W-1])
                replay_beat[k*ELEM_W +: ELEM_W] = ELEM_MIN;
            else if (!diff[ELEM_W] && (diff != '0))
                replay_beat[k*ELEM_W +: ELEM_W] = '0;
            else
                replay_beat[k*ELEM_W +: ELEM_W] = diff[ELEM_W-1:0];
        end
    end

    always_comb begin : fsm_next
        logic [DATA_W-1:0] res;
        res       = '0;
        state_d   = state_q;
        mode_d    = mode_q;
        count_d   = count_q;
        ctr_d     = ctr_q;
        rptr_d    = rptr_q;
        max_d     = max_q;
        sum_d     = sum_q;
        o_valid_d = o_valid_q;
        o_bits_d  = o_bits_q;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
        idx_d     = idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ext_start_i && (cfg_mode != M_RSVD) && (cfg_cnt != '0)
                    && (cfg_cnt <= BEAT_W'(MAX_BEATS))) begin
                    mode_d  = cfg_mode;
                    count_d = cfg_cnt;
                    ctr_d   = '0;
                    rptr_d  = '0;
                    max_d   = ELEM_MIN;
                    sum_d   = '0;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
                    idx_d   = '0;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_hs) begin
                    if (beat_max > max_q) begin
                        max_d = beat_max;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
                        idx_d = IDX_W'(ctr_q) * IDX_W'(LANES) + beat_lane;
`endif
                    end
                    sum_d = sum_q + beat_sum;
                    ctr_d = ctr_q + BEAT_W'(1);
                    if (ctr_q == count_q - BEAT_W'(1)) begin
                        if (mode_q == M_MAXSUB) begin
                            state_d = S_REPLAY;
                        end else begin
                            if (mode_q == M_SUM) begin
                                res = {{(DATA_W-ACC_W){sum_d[ACC_W-1]}}, sum_d};
                            end else begin
                                res[ELEM_W-1:0] = max_d;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
                                res[ELEM_W +: IDX_W] = idx_d;
`endif
                            end
                            o_bits_d  = res;
                            o_valid_d = 1'b1;
                            state_d   = S_RESULT;
                        end
                    end
                end
            end
            S_RESULT: begin
                if (out_hs) begin
                    o_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_REPLAY: begin
                if (!o_valid_q || bus.ext_data_o_ready) begin
                    if (rptr_q != count_q) begin
                        o_bits_d  = replay_beat;
                        o_valid_d = 1'b1;
                        rptr_d    = rptr_q + BEAT_W'(1);
                    end else begin
                        o_valid_d = 1'b0;
                        state_d   = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            mode_q    <= '0;
            count_q   <= '0;
            ctr_q     <= '0;
            rptr_q    <= '0;
            max_q     <= '0;
            sum_q     <= '0;
            o_valid_q <= 1'b0;
            o_bits_q  <= '0;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
            idx_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            count_q   <= count_d;
            ctr_q     <= ctr_d;
            rptr_q    <= rptr_d;
            max_q     <= max_d;
            sum_q     <= sum_d;
            o_valid_q <= o_valid_d;
            o_bits_q  <= o_bits_d;
`ifdef SFU_ROW_REDUCE_ARGMAX_EN
            idx_q     <= idx_d;
`endif
        end
    end

    // Row buffer holds data only; it is never cleared.
    always_ff @(posedge clk_i) begin
        if (in_hs && (mode_q == M_MAXSUB))
            row_buf[ctr_q[PTR_W-1:0]] <= bus.ext_data_i_bits;
    end
endmodule
